vga_box_gen: RTL and testbench
==============================

// Module: vga_box_gen
// PURPOSE
//  Pixel-generation stage directly downstream of vga_sync. Consumes pixel_x,
//  pixel_y, video_on, hsync and vsync; renders a solid square that bounces off
//  the active-area edges, moving once per frame. Emits registered 12-bit RGB
//  with hsync/vsync delayed to stay pixel-aligned. Drives the VGA connector.
// PARAMETERS
//  H_ACTIVE   640      visible pixels per line
//  V_ACTIVE   480      visible lines per frame
//  BOX_SIZE   16       square edge in pixels (2..V_ACTIVE-1)
//  STEP       1        pixels moved per frame on each axis (1..BOX_SIZE-1)
//  BOX_COLOR  12'hF00  square colour {R4,G4,B4}
//  BG_COLOR   12'h00F  background colour inside active area
// PORTS
//  clk         in   1   pixel clock
//  rst         in   1   asynchronous reset, active-low
//  hsync_in    in   1   hsync from vga_sync (active low)
//  vsync_in    in   1   vsync from vga_sync (active low)
//  video_on    in   1   active-area flag from vga_sync
//  pixel_x     in   10  current column, 0..799
//  pixel_y     in   10  current row, 0..524
//  enable      in   1   1 = motion allowed; 0 = box frozen
//  rgb         out  12  pixel colour, registered
//  hsync_out   out  1   hsync_in delayed 2 clocks
//  vsync_out   out  1   vsync_in delayed 2 clocks
//  frame_tick  out  1   one-cycle pulse per frame, registered
//  bounce_cnt  out  8   frames with at least one reflection, wraps 255->0
// BEHAVIOUR
//  Reset (rst=0, async): rgb=0, hsync_out=1, vsync_out=1, frame_tick=0,
//   bounce_cnt=0, x_pos=0, y_pos=0, x_dir=RIGHT, y_dir=DOWN, all pipe regs
//   cleared (video_on pipe=0, sync pipes=1). Deassertion takes effect next edge.
//  frame_tick: set for exactly one clock the cycle after the inputs show
//   pixel_x==0 && pixel_y==V_ACTIVE (first blanking line); otherwise 0.
//  Motion: updated only in the clock where frame_tick==1 and enable==1, so
//   position never changes during active video. Box covers
//   [x_pos, x_pos+BOX_SIZE-1] x [y_pos, y_pos+BOX_SIZE-1].
//  Per-axis direction FSM, two states (x: RIGHT/LEFT; y: DOWN/UP):
//   RIGHT: if x_pos+STEP >= H_ACTIVE-BOX_SIZE -> x_pos=H_ACTIVE-BOX_SIZE,
//          go LEFT, reflect; else x_pos+=STEP.
//   LEFT:  if x_pos <= STEP -> x_pos=0, go RIGHT, reflect; else x_pos-=STEP.
//   DOWN/UP identical with y_pos, V_ACTIVE.
//  Compare arithmetic 11-bit unsigned; no intermediate wrap. Positions 10-bit.
//  bounce_cnt: +1 in an update cycle where x, y or both reflect (corner hit
//   counts once). Wraps 8'hFF->8'h00.
//  Pipeline, latency 2 clocks from inputs to rgb/hsync_out/vsync_out:
//   S1 registers in_box (x and y range compare), video_on, hsync, vsync.
//   S2: rgb = !video_on_s1 ? 0 : in_box_s1 ? BOX_COLOR : BG_COLOR.
//  Position regs written on the tick edge; S1 sees new position next cycle.
//  Input pixel_x/y out of range (>=800/525) is not checked; no lockup.
// TESTING
//  1 rst=0 mid-line, no clk edge -> rgb=0, hsync_out=1, vsync_out=1,
//    bounce_cnt=0 at once; rst=1 -> box at (0,0), dirs RIGHT/DOWN.
//  2 x=5,y=5,video_on=1 -> rgb=12'hF00 exactly 2 clks later; x=16,y=5 ->
//    12'h00F; video_on=0 -> 12'h000; hsync_in low pulse reappears 2 clks later.
//  3 x=0,y=480, enable=1 -> frame_tick=1 one clk later for 1 clk; x_pos 0->1,
//    y_pos 0->1; repeat with enable=0 -> tick pulses, position unchanged.
//  4 Run 623 more frames -> x_pos=624, x_dir=LEFT, bounce_cnt+1; next frame
//    x_pos=623. y reaches 464 at frame 464, flips UP.
//  5 BOX_SIZE=16,STEP=1 run to frame where x and y reflect together (square
//    640x480 corner via forced start) -> bounce_cnt increments by 1 only.
//  6 Drive 256 reflecting frames -> bounce_cnt 255 wraps to 0, no other effect.

Source files
------------

// File: rtl/vga_box_if.sv
// Pixel-stream bundle between vga_sync and the box renderer, plus the VGA connector outputs.
interface vga_box_if;
    logic        hsync_in;
    logic        vsync_in;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        enable;
    logic [11:0] rgb;
    logic        hsync_out;
    logic        vsync_out;
    logic        frame_tick;
    logic [7:0]  bounce_cnt;

    // Timing source side: drives the scan position and sync, observes the pixel output.
    modport master (
        output hsync_in, vsync_in, video_on, pixel_x, pixel_y, enable,
        input  rgb, hsync_out, vsync_out, frame_tick, bounce_cnt
    );

    // Renderer side.
    modport slave (
        input  hsync_in, vsync_in, video_on, pixel_x, pixel_y, enable,
        output rgb, hsync_out, vsync_out, frame_tick, bounce_cnt
    );
endinterface

// File: rtl/vga_box_gen.sv
// Bouncing-square pixel generator: two-stage pixel pipeline plus per-frame box motion.
module vga_box_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned BOX_SIZE  = 16,
    parameter int unsigned STEP      = 1,
    parameter logic [11:0] BOX_COLOR = 12'hF00,
    parameter logic [11:0] BG_COLOR  = 12'h00F
) (
    input  logic       clk,
    input  logic       rst,
    vga_box_if.slave   bus
);

    localparam int unsigned PW    = 10;
    localparam int unsigned CW    = 11;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned RGB_W = 12;

    localparam logic [CW-1:0] X_MAX    = CW'(H_ACTIVE - BOX_SIZE);
    localparam logic [CW-1:0] Y_MAX    = CW'(V_ACTIVE - BOX_SIZE);
    localparam logic [CW-1:0] STEP_C   = CW'(STEP);
    localparam logic [CW-1:0] BOX_LAST = CW'(BOX_SIZE - 1);
    localparam logic [PW-1:0] TICK_Y   = PW'(V_ACTIVE);

    typedef enum logic {X_RIGHT, X_LEFT} x_dir_e;
    typedef enum logic {Y_DOWN,  Y_UP}   y_dir_e;

    x_dir_e             x_dir, x_dir_nxt;
    y_dir_e             y_dir, y_dir_nxt;
    logic [PW-1:0]      x_pos, x_pos_nxt;
    logic [PW-1:0]      y_pos, y_pos_nxt;
    logic [CNT_W-1:0]   bounce_q, bounce_nxt;
    logic               x_reflect, y_reflect;
    logic               tick_q;

    logic               in_box_s1, video_s1, hsync_s1, vsync_s1;
    logic [RGB_W-1:0]   rgb_q;
    logic               hsync_q, vsync_q;

    logic [CW-1:0]      px, py, xl, yl;
    logic               in_box;

    assign px = CW'(bus.pixel_x);
    assign py = CW'(bus.pixel_y);
    assign xl = CW'(x_pos);
    assign yl = CW'(y_pos);
    assign in_box = (px >= xl) && (px <= xl + BOX_LAST) &&
                    (py >= yl) && (py <= yl + BOX_LAST);

    // Direction state, position and reflection counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_dir    <= X_RIGHT;
            y_dir    <= Y_DOWN;
            x_pos    <= '0;
            y_pos    <= '0;
            bounce_q <= '0;
        end else begin
            x_dir    <= x_dir_nxt;
            y_dir    <= y_dir_nxt;
            x_pos    <= x_pos_nxt;
            y_pos    <= y_pos_nxt;
            bounce_q <= bounce_nxt;
        end
    end

    // Per-axis bounce FSMs; only step on an enabled frame tick so active video never sees a move.
    always_comb begin
        x_dir_nxt  = x_dir;
        y_dir_nxt  = y_dir;
        x_pos_nxt  = x_pos;
        y_pos_nxt  = y_pos;
        x_reflect  = 1'b0;
        y_reflect  = 1'b0;
        bounce_nxt = bounce_q;
        if (tick_q && bus.enable) begin
            case (x_dir)
                X_RIGHT: begin
                    if (xl + STEP_C >= X_MAX) begin
                        x_pos_nxt = PW'(X_MAX);
                        x_dir_nxt = X_LEFT;
                        x_reflect = 1'b1;
                    end else begin
                        x_pos_nxt = x_pos + PW'(STEP);
                    end
                end
                default: begin
                    if (xl <= STEP_C) begin
                        x_pos_nxt = '0;
                        x_dir_nxt = X_RIGHT;
                        x_reflect = 1'b1;
                    end else begin
                        x_pos_nxt = x_pos - PW'(STEP);
                    end
                end
            endcase
            case (y_dir)
                Y_DOWN: begin
                    if (yl + STEP_C >= Y_MAX) begin
                        y_pos_nxt = PW'(Y_MAX);
                        y_dir_nxt = Y_UP;
                        y_reflect = 1'b1;
                    end else begin
                        y_pos_nxt = y_pos + PW'(STEP);
                    end
                end
                default: begin
                    if (yl <= STEP_C) begin
                        y_pos_nxt = '0;
                        y_dir_nxt = Y_DOWN;
                        y_reflect = 1'b1;
                    end else begin
                        y_pos_nxt = y_pos - PW'(STEP);
                    end
                end
            endcase
            if (x_reflect || y_reflect) begin
                bounce_nxt = bounce_q + CNT_W'(1);
            end
        end
    end

    // Frame tick: one pulse after the scan enters the first blanking line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= (bus.pixel_x == '0) && (bus.pixel_y == TICK_Y);
        end
    end

    // Two-stage pixel pipeline keeping rgb and sync aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_box_s1 <= 1'b0;
            video_s1  <= 1'b0;
            hsync_s1  <= 1'b1;
            vsync_s1  <= 1'b1;
            rgb_q     <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
        end else begin
            in_box_s1 <= in_box;
            video_s1  <= bus.video_on;
            hsync_s1  <= bus.hsync_in;
            vsync_s1  <= bus.vsync_in;
            rgb_q     <= !video_s1 ? '0 : (in_box_s1 ? BOX_COLOR : BG_COLOR);
            hsync_q   <= hsync_s1;
            vsync_q   <= vsync_s1;
        end
    end

    assign bus.rgb        = rgb_q;
    assign bus.hsync_out  = hsync_q;
    assign bus.vsync_out  = vsync_q;
    assign bus.frame_tick = tick_q;
    assign bus.bounce_cnt = bounce_q;

endmodule

// File: tb/tb_vga_box_gen.sv
// Self-checking bench for vga_box_gen: full-size instance plus a small fast-bouncing instance.
module tb_vga_box_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_box_if ia ();
    vga_box_if ib ();

    vga_box_gen #(.H_ACTIVE(640), .V_ACTIVE(480), .BOX_SIZE(16), .STEP(1),
                  .BOX_COLOR(12'hF00), .BG_COLOR(12'h00F))
        dut0 (.clk(clk), .rst(rst), .bus(ia));

    vga_box_gen #(.H_ACTIVE(48), .V_ACTIVE(40), .BOX_SIZE(16), .STEP(4),
                  .BOX_COLOR(12'hF00), .BG_COLOR(12'h00F))
        dut1 (.clk(clk), .rst(rst), .bus(ib));

    int total = 0;
    int bad   = 0;

    // Reference model: box position, direction and reflection count per instance.
    int hact [2] = '{640, 48};
    int vact [2] = '{480, 40};
    int stp  [2] = '{1, 4};
    int bsz      = 16;
    int mx   [2];
    int my   [2];
    bit mleft[2];
    bit mup  [2];
    int mcnt [2];
    bit en   [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mx[d] = 0; my[d] = 0; mleft[d] = 0; mup[d] = 0; mcnt[d] = 0;
        end
    endtask

    task automatic model_frame(input int d, output bit rx, output bit ry);
        int xm, ym;
        xm = hact[d] - bsz;
        ym = vact[d] - bsz;
        rx = 0; ry = 0;
        if (!mleft[d]) begin
            if (mx[d] + stp[d] >= xm) begin mx[d] = xm; mleft[d] = 1; rx = 1; end
            else mx[d] = mx[d] + stp[d];
        end else begin
            if (mx[d] <= stp[d]) begin mx[d] = 0; mleft[d] = 0; rx = 1; end
            else mx[d] = mx[d] - stp[d];
        end
        if (!mup[d]) begin
            if (my[d] + stp[d] >= ym) begin my[d] = ym; mup[d] = 1; ry = 1; end
            else my[d] = my[d] + stp[d];
        end else begin
            if (my[d] <= stp[d]) begin my[d] = 0; mup[d] = 0; ry = 1; end
            else my[d] = my[d] - stp[d];
        end
        if (rx || ry) mcnt[d] = (mcnt[d] + 1) % 256;
    endtask

    function automatic logic [11:0] exp_rgb(input int d, input int x, input int y, input bit von);
        if (!von) return 12'h000;
        if (x >= mx[d] && x < mx[d] + bsz && y >= my[d] && y < my[d] + bsz) return 12'hF00;
        return 12'h00F;
    endfunction

    // Input drivers and output readers.
    task automatic set_in(input int d, input int x, input int y, input bit von,
                          input bit hs, input bit vs);
        if (d == 0) begin
            ia.pixel_x = 10'(x); ia.pixel_y = 10'(y); ia.video_on = von;
            ia.hsync_in = hs; ia.vsync_in = vs; ia.enable = en[0];
        end else begin
            ib.pixel_x = 10'(x); ib.pixel_y = 10'(y); ib.video_on = von;
            ib.hsync_in = hs; ib.vsync_in = vs; ib.enable = en[1];
        end
    endtask

    task automatic idle(input int d);
        set_in(d, 700, 500, 0, 1, 1);
    endtask

    function automatic logic [11:0] get_rgb(input int d);
        return (d == 0) ? ia.rgb : ib.rgb;
    endfunction
    function automatic logic get_tick(input int d);
        return (d == 0) ? ia.frame_tick : ib.frame_tick;
    endfunction
    function automatic logic [7:0] get_cnt(input int d);
        return (d == 0) ? ia.bounce_cnt : ib.bounce_cnt;
    endfunction

    task automatic sample_px(input int d, input int x, input int y, input bit von,
                             output logic [11:0] got);
        set_in(d, x, y, von, 1, 1);
        @(posedge clk); #1;
        idle(d);
        @(posedge clk); #1;
        got = get_rgb(d);
    endtask

    // One frame: present the first blanking pixel, then idle while the tick is acted on.
    task automatic run_frame(input int d, input bit e, output logic t1, output logic t2,
                             output logic [7:0] cnt, output bit rx, output bit ry);
        en[d] = e;
        set_in(d, 0, vact[d], 0, 1, 1);
        @(posedge clk); #1;
        t1 = get_tick(d);
        idle(d);
        @(posedge clk); #1;
        t2 = get_tick(d);
        cnt = get_cnt(d);
        rx = 0; ry = 0;
        if (e) model_frame(d, rx, ry);
    endtask

    task automatic verify_box(input int d, input string tag);
        int px [6];
        int py [6];
        bit use_pt [6];
        logic [11:0] got, exp;
        px[0] = mx[d];           py[0] = my[d];           use_pt[0] = 1;
        px[1] = mx[d] + bsz - 1; py[1] = my[d] + bsz - 1; use_pt[1] = 1;
        px[2] = mx[d] + bsz;     py[2] = my[d];           use_pt[2] = (px[2] < hact[d]);
        px[3] = mx[d] - 1;       py[3] = my[d];           use_pt[3] = (mx[d] > 0);
        px[4] = mx[d];           py[4] = my[d] + bsz;     use_pt[4] = (py[4] < vact[d]);
        px[5] = mx[d];           py[5] = my[d] - 1;       use_pt[5] = (my[d] > 0);
        for (int k = 0; k < 6; k++) begin
            if (use_pt[k]) begin
                sample_px(d, px[k], py[k], 1, got);
                exp = exp_rgb(d, px[k], py[k], 1);
                total++;
                if (got !== exp) begin
                    bad++;
                    $display("FAIL %s dut%0d pt(%0d,%0d) rgb=%h want %h", tag, d, px[k], py[k], got, exp);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en[0] = 0; en[1] = 0;
        idle(0); idle(1);
        model_reset();
        #2 rst = 1'b0;
        #1;
        total++;
        if (ia.rgb !== 12'h000 || ia.hsync_out !== 1'b1 || ia.vsync_out !== 1'b1 ||
            ia.frame_tick !== 1'b0 || ia.bounce_cnt !== 8'h00) begin
            bad++;
            $display("FAIL reset_dut0 rgb=%h hs=%b vs=%b tick=%b cnt=%h want 000 1 1 0 00",
                     ia.rgb, ia.hsync_out, ia.vsync_out, ia.frame_tick, ia.bounce_cnt);
        end
        total++;
        if (ib.rgb !== 12'h000 || ib.bounce_cnt !== 8'h00 || ib.frame_tick !== 1'b0) begin
            bad++;
            $display("FAIL reset_dut1 rgb=%h tick=%b cnt=%h want 000 0 00", ib.rgb, ib.frame_tick, ib.bounce_cnt);
        end
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        verify_box(0, "reset_pos");
        verify_box(1, "reset_pos");
    endtask

    task automatic test_pipeline();
        logic [11:0] got;
        idle(0);
        repeat (2) @(posedge clk);
        #1;
        set_in(0, 5, 5, 1, 1, 1);
        @(posedge clk); #1;
        total++;
        if (ia.rgb !== 12'h000) begin bad++; $display("FAIL pipe_lat1 rgb=%h want 000", ia.rgb); end
        idle(0);
        @(posedge clk); #1;
        total++;
        if (ia.rgb !== 12'hF00) begin bad++; $display("FAIL pipe_lat2 rgb=%h want F00", ia.rgb); end
        @(posedge clk); #1;
        total++;
        if (ia.rgb !== 12'h000) begin bad++; $display("FAIL pipe_lat3 rgb=%h want 000", ia.rgb); end
        sample_px(0, 16, 5, 1, got);
        total++;
        if (got !== 12'h00F) begin bad++; $display("FAIL pipe_bg rgb=%h want 00F", got); end
        sample_px(0, 5, 5, 0, got);
        total++;
        if (got !== 12'h000) begin bad++; $display("FAIL pipe_blank rgb=%h want 000", got); end
        for (int s = 0; s < 2; s++) begin
            set_in(0, 700, 500, 0, (s == 0) ? 1'b0 : 1'b1, (s == 1) ? 1'b0 : 1'b1);
            for (int c = 1; c <= 3; c++) begin
                @(posedge clk); #1;
                idle(0);
                total++;
                if (((s == 0) ? ia.hsync_out : ia.vsync_out) !== ((c == 2) ? 1'b0 : 1'b1)) begin
                    bad++;
                    $display("FAIL sync_delay %s clk%0d got=%b want=%b", (s == 0) ? "hs" : "vs", c,
                             (s == 0) ? ia.hsync_out : ia.vsync_out, (c == 2) ? 1'b0 : 1'b1);
                end
            end
        end
    endtask

    task automatic test_frame_tick();
        logic t1, t2;
        logic [7:0] cnt;
        bit rx, ry;
        for (int e = 1; e >= 0; e--) begin
            run_frame(0, 1'(e), t1, t2, cnt, rx, ry);
            total++;
            if (t1 !== 1'b1 || t2 !== 1'b0) begin
                bad++;
                $display("FAIL tick_pulse en=%0d t1=%b t2=%b want 1 0", e, t1, t2);
            end
            total++;
            if (cnt !== 8'(mcnt[0])) begin bad++; $display("FAIL tick_cnt got=%h want %h", cnt, 8'(mcnt[0])); end
            verify_box(0, (e == 1) ? "move_1" : "frozen");
        end
    endtask

    task automatic test_bounce_x();
        logic t1, t2;
        logic [7:0] cnt;
        bit rx, ry;
        for (int f = 0; f < 624; f++) begin
            run_frame(0, 1'b1, t1, t2, cnt, rx, ry);
            total++;
            if (t1 !== 1'b1 || t2 !== 1'b0 || cnt !== 8'(mcnt[0])) begin
                bad++;
                $display("FAIL bounce_x_frame f=%0d t1=%b t2=%b cnt=%h want 1 0 %h", f, t1, t2, cnt, 8'(mcnt[0]));
            end
            if (rx || ry || f == 623 || $urandom_range(0, 63) == 0) verify_box(0, "bounce_x");
        end
    endtask

    task automatic test_random_pixels(input int d);
        logic [11:0] exp_q [$];
        logic        hs_q  [$];
        logic [11:0] e;
        logic        h;
        int x, y;
        bit von, hs;
        for (int i = 0; i <= 200; i++) begin
            if (i < 200) begin
                x = $urandom_range(0, 799);
                y = (d == 0) ? $urandom_range(0, 524) : $urandom_range(0, 60);
                if (x == 0 && y == vact[d]) x = 1;
                von = 1'($urandom_range(0, 3) != 0);
                hs  = 1'($urandom_range(0, 1));
                set_in(d, x, y, von, hs, 1);
                exp_q.push_back(exp_rgb(d, x, y, von));
                hs_q.push_back(hs);
            end else begin
                idle(d);
            end
            @(posedge clk); #1;
            if (i >= 1) begin
                e = exp_q.pop_front();
                h = hs_q.pop_front();
                total++;
                if (get_rgb(d) !== e || ((d == 0) ? ia.hsync_out : ib.hsync_out) !== h) begin
                    bad++;
                    $display("FAIL rand_px dut%0d i=%0d rgb=%h hs=%b want %h %b", d, i, get_rgb(d),
                             (d == 0) ? ia.hsync_out : ib.hsync_out, e, h);
                end
            end
        end
    endtask

    task automatic test_corner();
        logic t1, t2;
        logic [7:0] cnt;
        bit rx, ry;
        int seen = 0;
        for (int f = 0; f < 24; f++) begin
            run_frame(1, 1'b1, t1, t2, cnt, rx, ry);
            total++;
            if (cnt !== 8'(mcnt[1])) begin
                bad++;
                $display("FAIL corner_cnt f=%0d got=%h want %h rx=%0d ry=%0d", f, cnt, 8'(mcnt[1]), rx, ry);
            end
            if (rx && ry) begin
                seen++;
                verify_box(1, "corner");
            end
        end
        total++;
        if (seen != 1) begin bad++; $display("FAIL corner_seen got=%0d want 1", seen); end
    endtask

    task automatic test_wrap();
        logic t1, t2;
        logic [7:0] cnt;
        bit rx, ry, e;
        int refl = 0;
        int f = 0;
        while (refl < 300 && f < 4000) begin
            e = 1'($urandom_range(0, 3) != 0);
            run_frame(1, e, t1, t2, cnt, rx, ry);
            if (rx || ry) refl++;
            total++;
            if (t1 !== 1'b1 || t2 !== 1'b0 || cnt !== 8'(mcnt[1])) begin
                bad++;
                $display("FAIL wrap_frame f=%0d t1=%b t2=%b cnt=%h want 1 0 %h", f, t1, t2, cnt, 8'(mcnt[1]));
            end
            if (f % 37 == 0) verify_box(1, "wrap");
            f++;
        end
        total++;
        if (refl < 300) begin bad++; $display("FAIL wrap_budget refl=%0d want >=300", refl); end
        verify_box(1, "wrap_end");
    endtask

    task automatic test_reset_midrun();
        set_in(0, mx[0], my[0], 1, 1, 1);
        @(posedge clk); #1;
        idle(0);
        @(posedge clk);
        #4 rst = 1'b0;
        #1;
        total++;
        if (ia.rgb !== 12'h000 || ia.hsync_out !== 1'b1 || ia.frame_tick !== 1'b0 || ia.bounce_cnt !== 8'h00) begin
            bad++;
            $display("FAIL midrun_reset0 rgb=%h hs=%b tick=%b cnt=%h want 000 1 0 00",
                     ia.rgb, ia.hsync_out, ia.frame_tick, ia.bounce_cnt);
        end
        total++;
        if (ib.bounce_cnt !== 8'h00) begin bad++; $display("FAIL midrun_reset1 cnt=%h want 00", ib.bounce_cnt); end
        #2 rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        verify_box(0, "midrun_pos");
        verify_box(1, "midrun_pos");
    endtask

    initial begin
        test_reset();
        test_pipeline();
        test_frame_tick();
        test_bounce_x();
        test_random_pixels(0);
        test_corner();
        test_wrap();
        test_random_pixels(1);
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
